pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the fetch stage of the 16-bit processor. It generates the instruction memory address each cycle from one of several sources: sequential increment, branch target, call target, or a return address popped from an internal return-address stack (RAS). It keeps the existing branch-over-stall semantics and adds call/return support, configurable width, depth and reset vector, and optional trapping on stack misuse.

## Interface
Parameters:
- ADDR_W, 10, instruction address width in bits
- RAS_DEPTH, 8, return-address stack entries (≥2, power of two)
- RESET_VECTOR, 0, instr_address value after reset
- TRAP_VECTOR, 2**ADDR_W-1, redirect target on RAS overflow/underflow (only used with PC_RAS_TRAP_EN)

Ports:
- clk  input  1  clock; all state changes on posedge clk
- reset  input  1  synchronous, active-high; overrides every other input
- stall  input  1  holds the sequential increment only
- branch  input  1  redirect to br_address
- br_address  input  ADDR_W  branch target
- call  input  1  push return address, redirect to call_address
- call_address  input  ADDR_W  call target
- ret  input  1  pop return address and redirect to it
- instr_address  output  ADDR_W  current fetch address (registered)
- ras_count  output  $clog2(RAS_DEPTH+1)  valid RAS entries (registered)
- ras_empty  output  1  ras_count == 0
- ras_full  output  1  ras_count == RAS_DEPTH
- trap  output  1  one-cycle pulse on RAS overflow/underflow; constant 0 without PC_RAS_TRAP_EN

## Operation
- Per cycle, only one source is selected. Priority: reset > branch > call > ret > sequential. Any lower-priority request asserted in the same cycle is dropped, with no stack effect.
- Sequential: if !stall, then instr_address <= instr_address + 1, modulo 2^ADDR_W, so all-ones wraps to 0. If stall, hold.
- branch, call and ret act regardless of stall.
- Call, not full: push instr_address + 1 (mod 2^ADDR_W), instr_address <= call_address, ras_count increments.
- Ret, not empty: instr_address <= top entry, ras_count decrements.
- Call when full, without the macro: the push overwrites the oldest entry (circular pointer). The redirect still occurs and ras_count stays at RAS_DEPTH.
- Ret when empty, without the macro: treated as sequential, so it respects stall. The stack is unchanged.
- Stack contents are not cleared by reset. Only the pointer and count are reset.

## Timing
- All outputs are registered. A request sampled at edge N is visible on instr_address, ras_count and trap after edge N.
- Redirect latency is 1 cycle. No bubbles are generated internally.
- Reset values: instr_address = RESET_VECTOR, ras_count = 0, ras_empty = 1, ras_full = 0, trap = 0.
- Reset asserted in the middle of a call/ret sequence discards the whole stack state.
- Back-to-back call/ret on consecutive cycles is supported. A ret in the cycle after a call returns the address pushed by that call.

## Configuration
- Macro: PC_RAS_TRAP_EN.
- Defined:
  - Call when full: no push, instr_address <= TRAP_VECTOR, trap = 1 for one cycle, ras_count unchanged.
  - Ret when empty: instr_address <= TRAP_VECTOR, trap = 1 for one cycle. This ignores stall.
- Undefined: overwrite/no-op behaviour as in Operation; trap is tied to 0.

## Structure
- Shared package pc_pkg holds:
  - the enum pc_sel_e {SEL_HOLD, SEL_SEQ, SEL_BRANCH, SEL_CALL, SEL_RET, SEL_TRAP};
  - the default localparams for ADDR_W and RAS_DEPTH.
- The combinational priority select is in the top module. It produces a pc_sel_e value that drives the next-PC mux.
- One sub-module, pc_ras: a LIFO with
  - ports push, pop and push_data, and outputs top, count, full and empty;
  - a circular write pointer and a saturating count.

## Test plan
- Reset behaviour, with RESET_VECTOR=0: reset high for 2 cycles → instr_address=0, ras_empty=1. Release reset, no stall, 3 cycles → 1, 2, 3.
- Stall vs branch: stall=1 while instr_address=5 holds 5. stall=1 with branch=1 and br_address=0x40 → 0x40 on the next cycle.
- Call/return: at 0x10, call to 0x80 → 0x80, ras_count=1. Two sequential cycles → 0x82. ret → 0x11, ras_empty=1.
- Simultaneous requests: branch=1 (0x20), call=1 (0x30) and ret=1 in the same cycle → instr_address=0x20, ras_count unchanged.
- Overflow, RAS_DEPTH=8: 9 calls, without the macro → ras_count=8 and 8 rets return the newest 8 addresses. With PC_RAS_TRAP_EN, the 9th call → instr_address=TRAP_VECTOR, one-cycle trap pulse.
- Underflow and wrap: ret when empty, without the macro → PC increments. Separately, instr_address=0x3FF with ADDR_W=10, sequential → 0x000.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared next-PC source encoding and default sizing for the fetch-stage PC unit.
package pc_pkg;
    localparam int DEFAULT_ADDR_W = 10;
    localparam int DEFAULT_RAS_DEPTH = 8;
    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_SEQ,
        SEL_BRANCH,
        SEL_CALL,
        SEL_RET,
        SEL_TRAP
    } pc_sel_e;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: return-address LIFO with a circular write pointer, so a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int W = 10,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 push_data,
    output logic [W-1:0]                 top,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] top_ptr;
    assign top_ptr = wr_ptr - 1'b1;
    assign top = mem[top_ptr];
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    // Contents survive reset; only pointer and count are cleared.
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= push_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            count <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            count <= full ? count : count + 1'b1;
        end else if (pop && !empty) begin
            wr_ptr <= top_ptr;
            count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with branch/call/return and a return-address stack.
// Define PC_RAS_TRAP_EN to redirect to TRAP_VECTOR with a trap pulse on RAS overflow/underflow.
module pc_unit
    import pc_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int RAS_DEPTH = DEFAULT_RAS_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] TRAP_VECTOR = '1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             stall,
    input  logic                             branch,
    input  logic [ADDR_W-1:0]                br_address,
    input  logic                             call,
    input  logic [ADDR_W-1:0]                call_address,
    input  logic                             ret,
    output logic [ADDR_W-1:0]                instr_address,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_empty,
    output logic                             ras_full,
    output logic                             trap
);
`ifdef PC_RAS_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    pc_sel_e sel;
    pc_sel_e seq_sel;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] next_pc;
    assign seq_pc = instr_address + 1'b1;
    // Lower-priority requests are dropped outright; an unserviceable ret falls back to sequential.
    always_comb begin
        seq_sel = stall ? SEL_HOLD : SEL_SEQ;
        sel = branch ? SEL_BRANCH
            : call ? ((ras_full && TRAP_EN) ? SEL_TRAP : SEL_CALL)
            : (ret && !ras_empty) ? SEL_RET
            : (ret && TRAP_EN) ? SEL_TRAP
            : seq_sel;
    end
    always_comb begin
        next_pc = sel == SEL_SEQ ? seq_pc
                : sel == SEL_BRANCH ? br_address
                : sel == SEL_CALL ? call_address
                : sel == SEL_RET ? ras_top
                : sel == SEL_TRAP ? TRAP_VECTOR
                : instr_address;
    end
    always_ff @(posedge clk)
        instr_address <= reset ? RESET_VECTOR : next_pc;
`ifdef PC_RAS_TRAP_EN
    always_ff @(posedge clk)
        trap <= !reset && sel == SEL_TRAP;
`else
    assign trap = 1'b0;
`endif
    pc_ras #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
        .clk(clk),
        .reset(reset),
        .push(sel == SEL_CALL),
        .pop(sel == SEL_RET),
        .push_data(seq_pc),
        .top(ras_top),
        .count(ras_count),
        .full(ras_full),
        .empty(ras_empty)
    );
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit against a queue-based reference model.
module tb_pc_unit;
    localparam int AW = 10;
    localparam int D = 8;
    localparam logic [AW-1:0] TV = '1;
`ifdef PC_RAS_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    typedef struct {
        logic [AW-1:0] pc;
        int cnt;
        logic trap;
    } exp_t;
    logic clk = 1'b0;
    logic reset, stall, branch, call, ret;
    logic [AW-1:0] br_address, call_address, instr_address;
    logic [3:0] ras_count;
    logic ras_empty, ras_full, trap;
    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stk[$];
    logic m_trap;
    pc_unit #(.ADDR_W(AW), .RAS_DEPTH(D), .RESET_VECTOR('0), .TRAP_VECTOR(TV)) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .branch(branch),
        .br_address(br_address),
        .call(call),
        .call_address(call_address),
        .ret(ret),
        .instr_address(instr_address),
        .ras_count(ras_count),
        .ras_empty(ras_empty),
        .ras_full(ras_full),
        .trap(trap)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic step(input logic r, input logic s, input logic b, input logic [AW-1:0] ba,
                        input logic c, input logic [AW-1:0] ca, input logic rt);
        exp_t e;
        {reset, stall, branch, call, ret} = {r, s, b, c, rt};
        br_address = ba;
        call_address = ca;
        m_trap = 1'b0;
        if (r) begin
            m_pc = '0;
            m_stk.delete();
        end else if (b) begin
            m_pc = ba;
        end else if (c) begin
            if (TRAP_EN && m_stk.size() == D) begin
                m_pc = TV;
                m_trap = 1'b1;
            end else begin
                m_stk.push_back(m_pc + 1'b1);
                if (m_stk.size() > D) void'(m_stk.pop_front());
                m_pc = ca;
            end
        end else if (rt && m_stk.size() > 0) begin
            m_pc = m_stk.pop_back();
        end else if (rt && TRAP_EN) begin
            m_pc = TV;
            m_trap = 1'b1;
        end else if (!s) begin
            m_pc = m_pc + 1'b1;
        end
        sb.push_back('{m_pc, m_stk.size(), m_trap});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("pc", 32'(instr_address), 32'(e.pc));
        check("count", 32'(ras_count), 32'(e.cnt));
        check("empty", 32'(ras_empty), 32'(e.cnt == 0));
        check("full", 32'(ras_full), 32'(e.cnt == D));
        check("trap", 32'(trap), 32'(e.trap));
    endtask
    task automatic seq(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0, 0);
    endtask
    initial begin
        step(1, 0, 0, '0, 0, '0, 0);
        step(1, 0, 0, '0, 0, '0, 0);
        seq(3);
        seq(2);
        step(0, 1, 0, '0, 0, '0, 0);
        step(0, 1, 1, 10'h040, 0, '0, 0);
        step(0, 0, 1, 10'h010, 0, '0, 0);
        step(0, 0, 0, '0, 1, 10'h080, 0);
        seq(2);
        step(0, 0, 0, '0, 0, '0, 1);
        step(0, 0, 0, '0, 1, 10'h100, 0);
        step(0, 0, 1, 10'h020, 1, 10'h030, 1);
        step(0, 0, 0, '0, 0, '0, 1);
        step(0, 0, 0, '0, 0, '0, 1);
        step(0, 1, 0, '0, 0, '0, 1);
        step(0, 0, 0, '0, 1, 10'h050, 0);
        step(0, 1, 0, '0, 0, '0, 1);
        for (int i = 0; i < D + 1; i++) step(0, 0, 0, '0, 1, AW'(10'h200 + 4 * i), 0);
        for (int i = 0; i < D; i++) step(0, 0, 0, '0, 0, '0, 1);
        step(0, 0, 0, '0, 0, '0, 1);
        step(0, 0, 0, '0, 1, 10'h060, 0);
        step(0, 0, 0, '0, 1, 10'h070, 0);
        step(1, 0, 0, '0, 0, '0, 1);
        step(0, 0, 0, '0, 0, '0, 1);
        step(0, 0, 1, 10'h3FF, 0, '0, 0);
        seq(1);
        step(0, 0, 1, 10'h3FF, 0, '0, 0);
        step(0, 0, 0, '0, 1, 10'h123, 0);
        step(0, 0, 0, '0, 0, '0, 1);
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 AW'($urandom), $urandom_range(0, 4) == 0, AW'($urandom), $urandom_range(0, 3) == 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
